// File: rtl/ab_gen_pkg.sv
// Shared types for the a/b pulse generator: FSM state encoding and symbol values.
package ab_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } ab_state_t;

  localparam logic SYM_A = 1'b0;
  localparam logic SYM_B = 1'b1;

endpackage

// File: rtl/ab_sym_buf.sv
// Symbol buffer: DEPTH x 1 register array with a fill counter.
// Writes always land at waddr; the caller is expected to pass the current count.
module ab_sym_buf #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic                       wdata,
  input  logic                       clr,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic                       rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;

  // Symbol storage; contents survive reset and clear, only count is discarded.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fill counter: clear wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn)  count <= '0;
    else if (clr) count <= '0;
    else if (we)  count <= count + CW'(1);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ab_pulse_gen.sv
// a/b pulse generator top: buffers symbols and plays them back as timed,
// mutually exclusive pulses on a or b separated by idle gaps.
// Optional feature macro: AB_GEN_LOOP_EN adds the loop input for repeated playback.
//
// state | meaning
// IDLE  | loading allowed, waiting for start
// PULSE | a or b held high for PULSE_CYC cycles
// GAP   | both low for GAP_CYC cycles, then next symbol or finish
module ab_pulse_gen
  import ab_gen_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PULSE_CYC = 3,
  parameter int GAP_CYC   = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       sym_in,
  input  logic                       sym_push,
  input  logic                       clear,
  input  logic                       start,
`ifdef AB_GEN_LOOP_EN
  input  logic                       loop,
`endif
  output logic                       a,
  output logic                       b,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 state
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

  ab_state_t         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              a_d, b_d, busy_d, done_d;
  logic              buf_we, buf_clr, rd_sym, loop_en;

`ifdef AB_GEN_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  ab_sym_buf #(.DEPTH(DEPTH)) u_buf (
    .clk    (clk),
    .resetn (resetn),
    .we     (buf_we),
    .waddr  (count[IW-1:0]),
    .wdata  (sym_in),
    .clr    (buf_clr),
    .raddr  (idx_d),
    .rdata  (rd_sym),
    .count  (count)
  );

  // Next-state, buffer control and next-output decode; outputs follow the
  // next state so that they are registered yet aligned with state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    buf_we  = 1'b0;
    buf_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (count != '0)) begin
          state_d = ST_PULSE;
          idx_d   = '0;
          tmr_d   = PULSE_LD;
        end else if (clear) begin
          buf_clr = 1'b1;
        end else if (sym_push && (count != DEPTH_C)) begin
          buf_we = 1'b1;
        end
      end
      ST_PULSE: begin
        if (tmr_q == '0) begin
          state_d = ST_GAP;
          tmr_d   = GAP_LD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          if (CW'(idx_q) < (count - CW'(1))) begin
            state_d = ST_PULSE;
            idx_d   = idx_q + IW'(1);
            tmr_d   = PULSE_LD;
          end else if (loop_en) begin
            state_d = ST_PULSE;
            idx_d   = '0;
            tmr_d   = PULSE_LD;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tmr_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        tmr_d   = '0;
      end
    endcase
    a_d    = (state_d == ST_PULSE) && (rd_sym == SYM_A);
    b_d    = (state_d == ST_PULSE) && (rd_sym == SYM_B);
    busy_d = (state_d != ST_IDLE);
  end

  // State, index, timer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      a       <= 1'b0;
      b       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      a       <= a_d;
      b       <= b_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ab_pulse_gen.sv
// Self-checking bench for ab_pulse_gen (default parameters).
module tb_ab_pulse_gen;

  localparam int DEPTH = 16;
  localparam int P     = 3;
  localparam int G     = 2;
  localparam int PG    = P + G;

  logic       clk = 1'b0;
  logic       resetn, sym_in, sym_push, clear, start;
`ifdef AB_GEN_LOOP_EN
  logic       loop;
`endif
  logic       a, b, busy, done;
  logic [4:0] count;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ab_pulse_gen #(.DEPTH(DEPTH), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sym_in   (sym_in),
    .sym_push (sym_push),
    .clear    (clear),
    .start    (start),
`ifdef AB_GEN_LOOP_EN
    .loop     (loop),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .state    (state)
  );

  typedef struct {
    logic push;
    logic sym;
    logic clr;
    logic st;
    int   exp_count;
    int   exp_state;
    logic exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, c, act, exp);
    end
  endtask

  task automatic push_sym(input logic s);
    sym_push = 1'b1;
    sym_in   = s;
    step();
    sym_push = 1'b0;
  endtask

  task automatic clr_buf();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Plays n symbols from seq (bit i = symbol i) and checks every cycle up to
  // and including the done cycle against a cycle-position model.
  task automatic run_check(input string nm, input int n, input logic [31:0] seq,
                           input int exp_cnt, input bit prio, input bit inject,
                           output int pulses);
    logic prev;
    logic ea, eb, ebusy, edone;
    int   es, i, r;
    pulses = 0;
    prev   = 1'b0;
    start  = 1'b1;
    if (prio) begin
      sym_push = 1'b1;
      sym_in   = 1'b1;
      clear    = 1'b1;
    end
    for (int c = 1; c <= n * PG + 1; c++) begin
      step();
      start    = 1'b0;
      sym_push = 1'b0;
      clear    = 1'b0;
      if (c <= n * PG) begin
        i     = (c - 1) / PG;
        r     = (c - 1) % PG;
        ea    = (r < P) && !seq[i];
        eb    = (r < P) && seq[i];
        es    = (r < P) ? 1 : 2;
        ebusy = 1'b1;
        edone = 1'b0;
      end else begin
        ea = 1'b0; eb = 1'b0; es = 0; ebusy = 1'b0; edone = 1'b1;
      end
      chk({nm, "_a"}, c, 32'(a), 32'(ea));
      chk({nm, "_b"}, c, 32'(b), 32'(eb));
      chk({nm, "_busy"}, c, 32'(busy), 32'(ebusy));
      chk({nm, "_done"}, c, 32'(done), 32'(edone));
      chk({nm, "_state"}, c, 32'(state), 32'(es));
      chk({nm, "_count"}, c, 32'(count), 32'(exp_cnt));
      if ((a | b) && !prev) pulses++;
      prev = a | b;
      if (inject) begin
        if (c == 3) begin sym_push = 1'b1; sym_in = 1'b1; end
        if (c == 5) clear = 1'b1;
        if (c == 7) start = 1'b1;
      end
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] seq;

    vecs[0] = '{push:0, sym:0, clr:0, st:1, exp_count:0, exp_state:0, exp_busy:0};
    vecs[1] = '{push:1, sym:0, clr:0, st:0, exp_count:1, exp_state:0, exp_busy:0};
    vecs[2] = '{push:1, sym:1, clr:0, st:0, exp_count:2, exp_state:0, exp_busy:0};
    vecs[3] = '{push:1, sym:1, clr:1, st:0, exp_count:0, exp_state:0, exp_busy:0};
    vecs[4] = '{push:1, sym:1, clr:0, st:0, exp_count:1, exp_state:0, exp_busy:0};
    vecs[5] = '{push:1, sym:0, clr:0, st:0, exp_count:2, exp_state:0, exp_busy:0};
    vecs[6] = '{push:0, sym:0, clr:1, st:0, exp_count:0, exp_state:0, exp_busy:0};
    vecs[7] = '{push:1, sym:0, clr:0, st:0, exp_count:1, exp_state:0, exp_busy:0};
    vecs[8] = '{push:1, sym:1, clr:1, st:0, exp_count:0, exp_state:0, exp_busy:0};

    resetn = 1'b0; sym_in = 1'b0; sym_push = 1'b0; clear = 1'b0; start = 1'b0;
`ifdef AB_GEN_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) step();
    chk("rst_a", 0, 32'(a), 0);
    chk("rst_b", 0, 32'(b), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_done", 0, 32'(done), 0);
    chk("rst_count", 0, 32'(count), 0);
    chk("rst_state", 0, 32'(state), 0);
    resetn = 1'b1;
    step();

    // Loading, clear priority and empty start
    for (int k = 0; k < 9; k++) begin
      sym_push = vecs[k].push;
      sym_in   = vecs[k].sym;
      clear    = vecs[k].clr;
      start    = vecs[k].st;
      step();
      sym_push = 1'b0; clear = 1'b0; start = 1'b0;
      chk("vec_count", k, 32'(count), 32'(vecs[k].exp_count));
      chk("vec_state", k, 32'(state), 32'(vecs[k].exp_state));
      chk("vec_busy", k, 32'(busy), 32'(vecs[k].exp_busy));
    end

    // Basic playback a,b,a,a with start beating push/clear in the same cycle
    clr_buf();
    push_sym(0); push_sym(1); push_sym(0); push_sym(0);
    run_check("basic", 4, 32'b0010, 4, 1'b1, 1'b0, pulses);
    chk("basic_pulses", 0, 32'(pulses), 4);
    step();

    // Back-to-back replay of b,b,a; second pass carries ignored mid-run requests
    clr_buf();
    push_sym(1); push_sym(1); push_sym(0);
    run_check("replay1", 3, 32'b011, 3, 1'b0, 1'b0, pulses);
    run_check("replay2", 3, 32'b011, 3, 1'b0, 1'b1, pulses);
    chk("replay_pulses", 0, 32'(pulses), 3);
    step();

    // Overflow: 17 pushes, 16 kept and played
    clr_buf();
    seq = '0;
    for (int k = 0; k < 17; k++) begin
      push_sym((k % 3) == 0);
      if (k < 16) seq[k] = ((k % 3) == 0);
    end
    chk("ovf_count", 0, 32'(count), 16);
    run_check("ovf", 16, seq, 16, 1'b0, 1'b0, pulses);
    chk("ovf_pulses", 0, 32'(pulses), 16);
    step();

    // Reset during the second pulse
    clr_buf();
    push_sym(0); push_sym(1);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
    end
    chk("mid_b_high", 7, 32'(b), 1);
    resetn = 1'b0;
    step();
    chk("mrst_a", 0, 32'(a), 0);
    chk("mrst_b", 0, 32'(b), 0);
    chk("mrst_count", 0, 32'(count), 0);
    chk("mrst_state", 0, 32'(state), 0);
    chk("mrst_done", 0, 32'(done), 0);
    chk("mrst_busy", 0, 32'(busy), 0);
    resetn = 1'b1;
    step();

`ifdef AB_GEN_LOOP_EN
    // Loop a,b for three passes, dropping loop during the third
    push_sym(0); push_sym(1);
    loop  = 1'b1;
    start = 1'b1;
    begin
      int ndone = 0;
      logic ea, eb, ebusy, edone;
      int i, r;
      for (int c = 1; c <= 31; c++) begin
        step();
        start = 1'b0;
        if (c == 22) loop = 1'b0;
        if (c <= 30) begin
          i = (c - 1) / PG; r = (c - 1) % PG;
          ea = (r < P) && (i % 2 == 0);
          eb = (r < P) && (i % 2 == 1);
          ebusy = 1'b1; edone = 1'b0;
        end else begin
          ea = 1'b0; eb = 1'b0; ebusy = 1'b0; edone = 1'b1;
        end
        chk("loop_a", c, 32'(a), 32'(ea));
        chk("loop_b", c, 32'(b), 32'(eb));
        chk("loop_busy", c, 32'(busy), 32'(ebusy));
        chk("loop_done", c, 32'(done), 32'(edone));
        if (done) ndone++;
      end
      chk("loop_ndone", 0, 32'(ndone), 1);
    end
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ab_pulse_gen.md
# ab_pulse_gen

Symbol-stream pulse generator that drives the `a`/`b` inputs of the sequential detector labs. Symbols are buffered, then played back as timed, mutually exclusive pulses on `a` or `b`, separated by idle gaps. It sits upstream of a detector such as the `a`/`b` sequence FSM, either on-chip or in board bring-up, and replaces hand-written `a`/`b` stimulus.

## Interface
- `DEPTH`, 16: symbol buffer entries; must be ≥ 2.
- `PULSE_CYC`, 3: cycles a pulse is held high; must be ≥ 1.
- `GAP_CYC`, 2: cycles both outputs are low after each pulse; must be ≥ 1.
- `clk`, in, 1: single clock; all logic on rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `sym_in`, in, 1: symbol to load; 0 means pulse on `a`, 1 means pulse on `b`.
- `sym_push`, in, 1: write `sym_in` at index `count`.
- `clear`, in, 1: empty the buffer (IDLE only).
- `start`, in, 1: begin playback from index 0.
- `loop`, in, 1: present only with `AB_GEN_LOOP_EN`; repeat the sequence.
- `a`, out, 1: pulse output for symbol 0.
- `b`, out, 1: pulse output for symbol 1.
- `busy`, out, 1: high in PULSE and GAP.
- `done`, out, 1: one-cycle strobe at end of playback.
- `count`, out, `$clog2(DEPTH+1)`: number of loaded symbols.
- `state`, out, 2: FSM state; IDLE=0, PULSE=1, GAP=2.

## Operation
- **Reset** (`resetn`=0 at an edge): `a`=`b`=`busy`=`done`=0, `count`=0, `state`=IDLE, index and timer cleared. Reset overrides everything, including mid-playback, and outputs drop at that edge.
- **Loading (IDLE only):**
  - `sym_push` stores the symbol at index `count` and increments `count`.
  - A push is ignored when `count`==`DEPTH`, and always ignored outside IDLE.
  - `clear` sets `count`=0 and has priority over `sym_push` in the same cycle.
- **Start:**
  - `start` in IDLE with `count`>0 moves to PULSE with index 0. `start` has priority over `sym_push` and `clear` in the same cycle.
  - `start` with `count`==0 is ignored. `start` outside IDLE is ignored.
- **PULSE state:**
  - `a` = (sym==0), `b` = (sym==1). Exactly one is high.
  - Stays `PULSE_CYC` cycles, then moves to GAP.
- **GAP state:**
  - `a`=`b`=0 for `GAP_CYC` cycles.
  - Then, if index < `count`−1: increment index and go to PULSE.
  - Otherwise: go to IDLE and pulse `done`.
- **Buffer after playback:** contents and `count` are kept, so `start` replays the same sequence.
- **Register rules:** all outputs are registered; the timer saturates at no value and is reloaded on every state entry.

## Timing
- `start` sampled at edge 0 gives `state`=PULSE and the first pulse high from edge 1.
- Symbol i (0-based):
  - Pulse is high after edges 1+i·(P+G) through P+i·(P+G).
  - Gap occupies the next G cycles.
  - P=`PULSE_CYC`, G=`GAP_CYC`.
- With N symbols:
  - The FSM returns to IDLE at edge N·(P+G)+1.
  - `done`=1 for exactly that cycle; `busy` falls at the same edge.
- Back-to-back: `start` asserted while `done`=1 (IDLE) is accepted, so the next pulse begins one edge later.
- Between two identical symbols the output always drops for exactly G cycles.

## Configuration
- `AB_GEN_LOOP_EN` defined:
  - Adds the `loop` port.
  - At the end of the last GAP with `loop`=1, index wraps to 0 and the FSM goes to PULSE. `done` is not asserted and `busy` stays high.
  - Deasserting `loop` lets the current pass finish normally with `done`.
- Not defined:
  - No `loop` port; playback is always single-pass.

## Structure
- Package `ab_gen_pkg`:
  - State enum (IDLE/PULSE/GAP, 2 bits).
  - Symbol constants `SYM_A`=0, `SYM_B`=1.
- Sub-module `ab_sym_buf`:
  - DEPTH×1 register array.
  - Write port (`we`, `waddr`, `wdata`) and combinational read by index.
  - `count` register, with clear behaviour.
- Top level: FSM, timer and output registers.

## Test plan
- **Basic playback:** P=3, G=2; load a,b,a,a; start at edge 0.
  - `a` high in cycles 1–3, 11–13 and 16–18; `b` high in 6–8.
  - `done` high in cycle 21 only; `busy` high in cycles 1–20.
- **Overflow:** DEPTH=16; push 17 symbols.
  - `count`=16; the 17th is dropped.
  - Playback produces 16 pulses.
- **Empty and mid-run requests:**
  - `start` with `count`=0 leaves `state`=IDLE and `busy`=0.
  - `sym_push` or `clear` during playback leave `count` unchanged.
- **Reset mid-pulse:** `resetn`=0 during the second pulse.
  - Next cycle: `a`=`b`=0, `count`=0, `state`=0, no `done`.
- **Replay and priority:**
  - A second `start` while `done`=1 replays an identical waveform, including b,b separated by a 2-cycle gap.
  - Same-cycle `clear`+`sym_push` leaves `count`=0.
- **Loop (`AB_GEN_LOOP_EN`):** load a,b; `loop`=1 for 3 passes, then drop it.
  - Pattern a,b,a,b,a,b with no `done` between passes.
  - `done` exactly once, after the final pass.
